// File: rtl/laser_pkg.sv
// Shared types for the laser point-frame sequencer: packet opcodes, payload
// byte offsets and the playback state encoding.
package laser_pkg;

   typedef enum logic [7:0] {
      PKT_POINT = 8'h01,
      PKT_SWAP  = 8'h02
   } pkt_type_e;

   // Byte k of the payload sits at bits [8k+7:8k]; coordinates are big-endian.
   localparam int OFS_TYPE  = 0;
   localparam int OFS_X     = 1;
   localparam int OFS_Y     = 3;
   localparam int OFS_COLOR = 5;
   localparam int HDR_BYTES = 5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_LOAD    = 3'd2,
      ST_PRESENT = 3'd3,
      ST_DWELL   = 3'd4
   } play_state_e;

endpackage

// File: rtl/point_bank_ram.sv
// Simple dual-port point store holding both banks; address is {bank, index}.
// Read data is registered, so it appears one cycle after re_in.
module point_bank_ram #(
   parameter int WIDTH  = 56,
   parameter int ADDR_W = 11
) (
   input  logic              clock_in,
   input  logic              we_in,
   input  logic [ADDR_W-1:0] waddr_in,
   input  logic [WIDTH-1:0]  wdata_in,
   input  logic              re_in,
   input  logic [ADDR_W-1:0] raddr_in,
   output logic [WIDTH-1:0]  rdata_out
);

   logic [WIDTH-1:0] mem_q [2**ADDR_W];
   logic [WIDTH-1:0] rdata_q;

   // Write port and registered read port; the two banks never collide.
   always_ff @(posedge clock_in) begin
      if (we_in) begin
         mem_q[waddr_in] <= wdata_in;
      end
      if (re_in) begin
         rdata_q <= mem_q[raddr_in];
      end
   end

   assign rdata_out = rdata_q;

endmodule

// File: rtl/point_frame_sequencer.sv
// Double-buffered point-frame store and looping player.
// Packets (POINT / SWAP) fill the write bank; the display bank is replayed
// point by point with a per-point dwell. Bank swaps happen only while idle
// or on the handshake of a frame's last point.
//
//  state   | meaning
//  IDLE    | nothing to show, lasers blanked
//  FETCH   | RAM read of display bank[idx] issued
//  LOAD    | RAM data captured onto the point outputs
//  PRESENT | point valid, waiting for pt_ready_in
//  DWELL   | point accepted, holding for dwell_in cycles
module point_frame_sequencer
   import laser_pkg::*;
#(
   parameter int COORD_W  = 16,
   parameter int COLOR_CH = 3,
   parameter int DEPTH    = 1024,
   parameter int DWELL_W  = 32
) (
   input  logic                              clock_in,
   input  logic                              reset_in,
   input  logic                              pkt_doorbell_in,
   input  logic [8*(HDR_BYTES+COLOR_CH)-1:0] pkt_payload_in,
   input  logic [DWELL_W-1:0]                dwell_in,
   output logic                              pt_valid_out,
   input  logic                              pt_ready_in,
   output logic [COORD_W-1:0]                pt_x_out,
   output logic [COORD_W-1:0]                pt_y_out,
   output logic [8*COLOR_CH-1:0]             pt_color_out,
   output logic                              blank_out,
   output logic                              frame_done_out,
   output logic                              busy_out,
   output logic [15:0]                       drop_count_out,
   output logic                              disp_bank_out
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = IDX_W + 1;
   localparam int COL_W = 8 * COLOR_CH;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [COL_W-1:0]   colour;
   } point_t;

   localparam int PT_W = $bits(point_t);

   play_state_e         state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DWELL_W-1:0]  dwell_q, dwell_d;
   point_t              pt_q, pt_d;
   logic                pt_valid_q, pt_valid_d;
   logic                db_q, db_d;
   logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0]    disp_len_q, disp_len_d;
   logic                disp_bank_q, disp_bank_d;
   logic                swap_pend_q, swap_pend_d;
   logic [15:0]         drop_cnt_q, drop_cnt_d;

   logic [7:0]          pkt_type;
   logic [15:0]         pkt_x_raw, pkt_y_raw;
   point_t              pkt_point;
   logic                db_evt, is_idle, hs, last_pt, frame_done;
   logic                swap_pend_now, evt_swap_now, do_swap, drop;
   logic [CNT_W-1:0]    wr_base;
   logic                ram_we, ram_re;
   logic [IDX_W:0]      ram_waddr, ram_raddr;
   logic [PT_W-1:0]     ram_rdata;

   assign pkt_type         = pkt_payload_in[8*OFS_TYPE +: 8];
   assign pkt_x_raw        = {pkt_payload_in[8*OFS_X +: 8], pkt_payload_in[8*(OFS_X+1) +: 8]};
   assign pkt_y_raw        = {pkt_payload_in[8*OFS_Y +: 8], pkt_payload_in[8*(OFS_Y+1) +: 8]};
   assign pkt_point.x      = pkt_x_raw[COORD_W-1:0];
   assign pkt_point.y      = pkt_y_raw[COORD_W-1:0];
   assign pkt_point.colour = pkt_payload_in[8*OFS_COLOR +: COL_W];

   assign db_d       = pkt_doorbell_in;
   assign db_evt     = pkt_doorbell_in & ~db_q;
   assign is_idle    = (state_q == ST_IDLE);
   assign hs         = (state_q == ST_PRESENT) & pt_ready_in;
   assign last_pt    = ({1'b0, idx_q} == disp_len_q - CNT_W'(1));
   assign frame_done = hs & last_pt;

   // A pending swap fires when idle or at a frame end; a fresh SWAP only when
   // idle with nothing pending. Whatever event arrives alongside a pending
   // swap that fires is then treated against the new banks.
   assign swap_pend_now = swap_pend_q & (frame_done | is_idle);
   assign evt_swap_now  = db_evt & (pkt_type == PKT_SWAP) & ~swap_pend_q & is_idle;
   assign do_swap       = swap_pend_now | evt_swap_now;

   // Packet decode, bank swap, write-bank fill and drop accounting.
   always_comb begin
      wr_cnt_d    = wr_cnt_q;
      disp_len_d  = disp_len_q;
      disp_bank_d = disp_bank_q;
      swap_pend_d = swap_pend_q;
      drop_cnt_d  = drop_cnt_q;
      wr_base     = wr_cnt_q;
      ram_we      = 1'b0;
      ram_waddr   = '0;
      drop        = 1'b0;
      if (do_swap) begin
         disp_len_d  = wr_cnt_q;
         wr_cnt_d    = '0;
         disp_bank_d = ~disp_bank_q;
         swap_pend_d = 1'b0;
         wr_base     = '0;
      end
      if (db_evt && !evt_swap_now) begin
         if (swap_pend_q && !swap_pend_now) begin
            drop = 1'b1;
         end else if (pkt_type == PKT_POINT) begin
            if (wr_base < CNT_W'(DEPTH)) begin
               ram_we    = 1'b1;
               ram_waddr = {~disp_bank_d, wr_base[IDX_W-1:0]};
               wr_cnt_d  = wr_base + CNT_W'(1);
            end else begin
               drop = 1'b1;
            end
         end else if (pkt_type == PKT_SWAP) begin
            swap_pend_d = 1'b1;
         end
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   // Playback FSM next-state and point output staging.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      dwell_d    = dwell_q;
      pt_d       = pt_q;
      pt_valid_d = pt_valid_q;
      ram_re     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            pt_valid_d = 1'b0;
            if (disp_len_q != '0) begin
               state_d = ST_FETCH;
               idx_d   = '0;
            end
         end
         ST_FETCH: begin
            ram_re  = 1'b1;
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            pt_d       = point_t'(ram_rdata);
            pt_valid_d = 1'b1;
            state_d    = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (pt_ready_in) begin
               pt_valid_d = 1'b0;
               // The next index is settled here so a swap at frame end restarts at 0.
               idx_d = last_pt ? '0 : idx_q + IDX_W'(1);
               if (last_pt && (disp_len_d == '0)) begin
                  state_d = ST_IDLE;
               end else if (dwell_in == '0) begin
                  state_d = ST_FETCH;
               end else begin
                  dwell_d = dwell_in;
                  state_d = ST_DWELL;
               end
            end
         end
         ST_DWELL: begin
            dwell_d = dwell_q - DWELL_W'(1);
            if (dwell_q <= DWELL_W'(1)) begin
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ram_raddr = {disp_bank_q, idx_q};

   point_bank_ram #(
      .WIDTH  (PT_W),
      .ADDR_W (IDX_W + 1)
   ) u_ram (
      .clock_in  (clock_in),
      .we_in     (ram_we),
      .waddr_in  (ram_waddr),
      .wdata_in  (pkt_point),
      .re_in     (ram_re),
      .raddr_in  (ram_raddr),
      .rdata_out (ram_rdata)
   );

   // State registers with synchronous reset.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         dwell_q     <= '0;
         pt_q        <= '0;
         pt_valid_q  <= 1'b0;
         db_q        <= 1'b0;
         wr_cnt_q    <= '0;
         disp_len_q  <= '0;
         disp_bank_q <= 1'b0;
         swap_pend_q <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         dwell_q     <= dwell_d;
         pt_q        <= pt_d;
         pt_valid_q  <= pt_valid_d;
         db_q        <= db_d;
         wr_cnt_q    <= wr_cnt_d;
         disp_len_q  <= disp_len_d;
         disp_bank_q <= disp_bank_d;
         swap_pend_q <= swap_pend_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign pt_valid_out   = pt_valid_q;
   assign pt_x_out       = pt_q.x;
   assign pt_y_out       = pt_q.y;
   assign pt_color_out   = pt_q.colour;
   assign blank_out      = is_idle;
   assign frame_done_out = frame_done;
   assign busy_out       = swap_pend_q;
   assign drop_count_out = drop_cnt_q;
   assign disp_bank_out  = disp_bank_q;

endmodule
